pc_control: RTL and testbench

//  Program-counter / fetch-request stage that consumes the execute ALU's branch flag and result.

---
 rtl/pc_ctrl_pkg.sv | 23 ++
 rtl/pc_target_calc.sv | 34 +++
 rtl/pc_control.sv | 109 ++++++++++
 tb/tb_pc_control.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/pc_ctrl_pkg.sv
// rtl/pc_ctrl_pkg.sv - shared encodings for the program-counter control stage
// Purpose : ex_kind instruction classes and FSM state encodings used by
//           pc_control and pc_target_calc.
// Ports   : none (package).
package pc_ctrl_pkg;

  typedef enum logic [1:0] {
    KIND_SEQ    = 2'b00,
    KIND_BRANCH = 2'b01,
    KIND_JAL    = 2'b10,
    KIND_JALR   = 2'b11
  } ex_kind_e;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  // Instruction size in bytes; sequential fetch stride and link offset.
  localparam int unsigned INSN_BYTES = 4;

endpackage

// File: rtl/pc_target_calc.sv
// rtl/pc_target_calc.sv - combinational control-flow target resolution
// Purpose : from the instruction resolved in execute, compute whether control
//           flow is redirected, where to, and whether that target is misaligned.
// Ports   : ex_valid, ex_kind, ex_flag, ex_pc, ex_imm, ex_alu_result (in);
//           target, taken, misaligned (out).
module pc_target_calc
  import pc_ctrl_pkg::*;
#(
  parameter int BITWIDTH = 32
) (
  input  logic                ex_valid,
  input  logic [1:0]          ex_kind,
  input  logic                ex_flag,
  input  logic [BITWIDTH-1:0] ex_pc,
  input  logic [BITWIDTH-1:0] ex_imm,
  input  logic [BITWIDTH-1:0] ex_alu_result,
  output logic [BITWIDTH-1:0] target,
  output logic                taken,
  output logic                misaligned
);

  always_comb begin
    // JALR clears bit 0 of rs1+imm; PC-relative forms wrap modulo 2^BITWIDTH.
    if (ex_kind == KIND_JALR) begin
      target = ex_alu_result & ~BITWIDTH'(1);
    end else begin
      target = ex_pc + ex_imm;
    end
    taken = ex_valid & (((ex_kind == KIND_BRANCH) & ex_flag) |
                        (ex_kind == KIND_JAL) | (ex_kind == KIND_JALR));
    misaligned = |target[1:0];
  end

endmodule

// File: rtl/pc_control.sv
// rtl/pc_control.sv - fetch PC register, request issue and branch redirect
// Purpose : holds the fetch PC, issues sequential imem requests, redirects on
//           taken control flow with a one-cycle flush, halts on misaligned target.
// Ports   : clk, rst_n, ex_valid, ex_kind, ex_flag, ex_pc, ex_imm,
//           ex_alu_result, stall, imem_gnt (in);
//           imem_req, imem_addr, flush, link_addr, misalign_err, redirect_cnt (out).
module pc_control
  import pc_ctrl_pkg::*;
#(
  parameter int                   BITWIDTH     = 32,
  parameter logic [BITWIDTH-1:0]  RESET_VECTOR = '0,
  parameter int                   CNTWIDTH     = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ex_valid,
  input  logic [1:0]          ex_kind,
  input  logic                ex_flag,
  input  logic [BITWIDTH-1:0] ex_pc,
  input  logic [BITWIDTH-1:0] ex_imm,
  input  logic [BITWIDTH-1:0] ex_alu_result,
  input  logic                stall,
  input  logic                imem_gnt,
  output logic                imem_req,
  output logic [BITWIDTH-1:0] imem_addr,
  output logic                flush,
  output logic [BITWIDTH-1:0] link_addr,
  output logic                misalign_err,
  output logic [CNTWIDTH-1:0] redirect_cnt
);

  state_e              state_q, state_d;
  logic [BITWIDTH-1:0] pc_q;
  logic [BITWIDTH-1:0] target;
  logic                taken;
  logic                misaligned;
  logic                run;
  logic                redirect;
  logic                fault;

  pc_target_calc #(.BITWIDTH(BITWIDTH)) u_target (
    .ex_valid      (ex_valid),
    .ex_kind       (ex_kind),
    .ex_flag       (ex_flag),
    .ex_pc         (ex_pc),
    .ex_imm        (ex_imm),
    .ex_alu_result (ex_alu_result),
    .target        (target),
    .taken         (taken),
    .misaligned    (misaligned)
  );

  // Execute results only matter while running; BOOT and HALT ignore them.
  assign run      = (state_q == ST_RUN);
  assign redirect = run & taken & ~misaligned;
  assign fault    = run & taken & misaligned;

  assign imem_addr = pc_q;
  assign link_addr = ex_pc + BITWIDTH'(INSN_BYTES);

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_BOOT;
    else        state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN:  if (fault) state_d = ST_HALT;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_HALT;
    endcase
  end

  // FSM outputs
  always_comb begin
    imem_req = run & ~stall;
  end

  // A redirect overrides a same-cycle grant: that granted fetch is wrong-path
  // and is discarded by the flush pulse. A faulting target freezes the PC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_VECTOR;
    end else if (redirect) begin
      pc_q <= target;
    end else if (imem_req & imem_gnt & ~fault) begin
      pc_q <= pc_q + BITWIDTH'(INSN_BYTES);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush        <= 1'b0;
      misalign_err <= 1'b0;
      redirect_cnt <= '0;
    end else begin
      flush        <= redirect;
      misalign_err <= misalign_err | fault;
      if (redirect && !(&redirect_cnt)) begin
        redirect_cnt <= redirect_cnt + CNTWIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_pc_control.sv
// tb/tb_pc_control.sv - self-checking bench for pc_control
module tb_pc_control;

  localparam int CW = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid = 1'b0;
  logic [1:0]  ex_kind = 2'b00;
  logic        ex_flag = 1'b0;
  logic [31:0] ex_pc = '0;
  logic [31:0] ex_imm = '0;
  logic [31:0] ex_alu_result = '0;
  logic        stall = 1'b0;
  logic        imem_gnt = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        flush;
  logic [31:0] link_addr;
  logic        misalign_err;
  logic [CW-1:0] redirect_cnt;

  pc_control #(.BITWIDTH(32), .RESET_VECTOR(32'h0), .CNTWIDTH(CW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ex_valid      (ex_valid),
    .ex_kind       (ex_kind),
    .ex_flag       (ex_flag),
    .ex_pc         (ex_pc),
    .ex_imm        (ex_imm),
    .ex_alu_result (ex_alu_result),
    .stall         (stall),
    .imem_gnt      (imem_gnt),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .flush         (flush),
    .link_addr     (link_addr),
    .misalign_err  (misalign_err),
    .redirect_cnt  (redirect_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: "booted" = past the first cycle, "halted" = stopped on fault.
  bit          m_booted;
  bit          m_halted;
  logic [31:0] m_pc;
  bit          m_flush;
  bit          m_err;
  int          m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_booted = 0; m_halted = 0; m_pc = 32'h0; m_flush = 0; m_err = 0; m_cnt = 0;
  endtask

  // Called at a negedge; asserts reset asynchronously, checks, releases next negedge.
  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_req", {31'b0, imem_req}, 32'h0);
    chk("rst_flush", {31'b0, flush}, 32'h0);
    chk("rst_err", {31'b0, misalign_err}, 32'h0);
    chk("rst_cnt", {28'b0, redirect_cnt}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock cycle: drive inputs at a negedge, check outputs, advance model.
  task automatic cycle(input bit v, input logic [1:0] k, input bit f,
                       input logic [31:0] pc, input logic [31:0] imm,
                       input logic [31:0] alu, input bit st, input bit g);
    bit running, req, tk, xfer;
    logic [31:0] tgt;
    ex_valid = v; ex_kind = k; ex_flag = f; ex_pc = pc; ex_imm = imm;
    ex_alu_result = alu; stall = st; imem_gnt = g;
    #1;
    running = m_booted && !m_halted;
    req = running && !st;
    chk("addr", imem_addr, m_pc);
    chk("req", {31'b0, imem_req}, {31'b0, req});
    chk("flush", {31'b0, flush}, {31'b0, m_flush});
    chk("err", {31'b0, misalign_err}, {31'b0, m_err});
    chk("cnt", {28'b0, redirect_cnt}, m_cnt);
    chk("link", link_addr, pc + 32'd4);
    // Next-cycle expectations straight from the control-flow rules.
    tk = v && ((k == 2'd1 && f) || k == 2'd2 || k == 2'd3);
    tgt = (k == 2'd3) ? (alu & 32'hFFFF_FFFE) : (pc + imm);
    xfer = req && g;
    m_flush = 0;
    if (running && tk && (tgt % 4 == 0)) begin
      m_pc = tgt;
      m_flush = 1;
      if (m_cnt < (1 << CW) - 1) m_cnt++;
    end else if (running && tk) begin
      m_halted = 1;
      m_err = 1;
    end else if (xfer) begin
      m_pc = m_pc + 32'd4;
    end
    m_booted = 1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input bit st, input bit g);
    cycle(0, 2'd0, 0, 32'h0, 32'h0, 32'h0, st, g);
  endtask

  task automatic jal(input logic [31:0] pc, input logic [31:0] imm, input bit st, input bit g);
    cycle(1, 2'd2, 0, pc, imm, 32'h0, st, g);
  endtask

  initial begin
    @(negedge clk);
    // Reset release, boot cycle, sequential fetch
    apply_reset();
    idle(0, 1);
    idle(0, 1);
    idle(0, 1);
    idle(0, 1);
    chk("seq_addr_c", imem_addr, 32'hC);

    // Taken branch then not-taken branch
    cycle(1, 2'd1, 1, 32'h100, 32'h20, 32'h0, 0, 0);
    chk("br_addr", imem_addr, 32'h120);
    chk("br_flush", {31'b0, flush}, 32'h1);
    chk("br_cnt", {28'b0, redirect_cnt}, 32'h1);
    cycle(1, 2'd1, 0, 32'h100, 32'h20, 32'h0, 0, 0);
    chk("nt_addr", imem_addr, 32'h120);
    chk("nt_flush", {31'b0, flush}, 32'h0);

    // Grant withheld at 0x40
    jal(32'h0, 32'h40, 0, 0);
    idle(0, 0);
    idle(0, 0);
    idle(0, 0);
    chk("hold_addr", imem_addr, 32'h40);
    idle(0, 1);
    chk("gnt_addr", imem_addr, 32'h44);

    // Redirect with stall and same-cycle grant
    jal(32'h0, 32'h80, 1, 1);
    chk("st_addr", imem_addr, 32'h80);
    chk("st_flush", {31'b0, flush}, 32'h1);
    idle(1, 1);
    chk("st_req", {31'b0, imem_req}, 32'h0);
    idle(0, 0);

    // Address wrap, then reset in the middle of a redirect
    jal(32'h0, 32'hFFFF_FFFC, 0, 0);
    idle(0, 1);
    chk("wrap_addr", imem_addr, 32'h0);
    jal(32'h0, 32'h200, 0, 0);
    chk("mid_flush", {31'b0, flush}, 32'h1);
    apply_reset();

    // Misaligned JALR halts until reset
    idle(0, 1);
    cycle(1, 2'd3, 0, 32'h0, 32'h0, 32'h0000_2003, 0, 1);
    chk("halt_err", {31'b0, misalign_err}, 32'h1);
    chk("halt_req", {31'b0, imem_req}, 32'h0);
    jal(32'h0, 32'h300, 0, 1);
    idle(0, 1);
    chk("halt_addr", imem_addr, 32'h0);
    apply_reset();

    // Redirect counter saturation with back-to-back flushes
    idle(0, 1);
    for (int i = 0; i < 18; i++) jal(32'h0, 32'h1000 + 32'(i * 4), 0, 1);
    chk("sat_cnt", {28'b0, redirect_cnt}, 32'hF);
    chk("b2b_flush", {31'b0, flush}, 32'h1);

    // Randomized traffic
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      logic [31:0] rpc, rimm, ralu;
      if (i % 60 == 59) apply_reset();
      rpc  = $urandom & 32'hFFFF_FFFC;
      rimm = ($urandom_range(0, 15) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
      ralu = ($urandom_range(0, 15) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(0, 1));
      cycle($urandom_range(0, 3) == 0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            rpc, rimm, ralu, $urandom_range(0, 4) == 0, $urandom_range(0, 3) != 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
